i2s_audio_tx: RTL and testbench

//  Stereo I2S transmitter clocked by the 49.152 MHz audio PLL output (PLL outclk_0).

---
 rtl/i2s_audio_tx.sv | 236 +++++++++++++++++++++++
 tb/tb_i2s_audio_tx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_audio_tx.sv
// -----------------------------------------------------------------------------
// i2s_audio_tx
//
// Stereo I2S transmitter running from the 49.152 MHz audio PLL clock.
// Core logic hands over PCM sample pairs through a small FIFO. The block
// derives MCLK, SCLK (64 fs) and LRCK from the audio clock. It shifts each
// sample pair out MSB-first in Philips I2S format. Each channel sits in a
// 32-bit slot, and the data lags the LRCK edge by one bit.
//
// Optional feature macro: I2S_UNDERRUN_HOLD_EN
//   defined   : on underrun the last popped sample pair is replayed
//   undefined : on underrun silence (0/0) is played
//
// Parameters
//   SAMPLE_W    PCM bits per channel (1..31, padded to a 32-bit slot)
//   FIFO_DEPTH  sample-pair FIFO entries (power of 2, >= 2)
//   MCLK_DIV    clk_audio cycles per MCLK period (even, >= 2)
//   SCLK_DIV    clk_audio cycles per SCLK period (even, >= 4)
//
// Ports
//   clk_audio     in   audio PLL clock
//   reset_n       in   asynchronous active-low reset
//   sample_l      in   left PCM sample, two's complement
//   sample_r      in   right PCM sample, two's complement
//   sample_valid  in   sample pair presented
//   sample_ready  out  FIFO can accept; push on valid && ready
//   audio_mclk    out  master clock, 50% duty
//   audio_lrck    out  word select, 0 = left, 1 = right
//   audio_dac     out  serial data, changes on SCLK falling edge
//   audio_sclk    out  bit clock, 50% duty
//   underrun      out  1-cycle pulse when a frame load finds the FIFO empty
//   fifo_level    out  current FIFO occupancy
// -----------------------------------------------------------------------------
module i2s_audio_tx #(
  parameter int SAMPLE_W   = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int MCLK_DIV   = 4,
  parameter int SCLK_DIV   = 16
) (
  input  logic                          clk_audio,
  input  logic                          reset_n,
  input  logic [SAMPLE_W-1:0]           sample_l,
  input  logic [SAMPLE_W-1:0]           sample_r,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic                          audio_mclk,
  output logic                          audio_lrck,
  output logic                          audio_dac,
  output logic                          audio_sclk,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int MHALF = MCLK_DIV / 2;
  localparam int SHALF = SCLK_DIV / 2;
  localparam int MCW   = (MHALF > 1) ? $clog2(MHALF) : 1;
  localparam int SCW   = (SHALF > 1) ? $clog2(SHALF) : 1;
  localparam int PAD_W = 32 - SAMPLE_W;

  // Clock divider state
  logic [MCW-1:0] mclk_cnt;
  logic           mclk_q;
  logic [SCW-1:0] sclk_cnt;
  logic           sclk_q;

  // Framing state
  logic           fall_tick;
  logic           frame_wrap;
  logic [5:0]     bit_cnt;
  logic [31:0]    shift_l;
  logic [31:0]    shift_r;
  logic           dac_q;
  logic           underrun_q;
  logic [SAMPLE_W-1:0] held_l;
  logic [SAMPLE_W-1:0] held_r;

  // FIFO state
  logic [SAMPLE_W-1:0] mem_l [FIFO_DEPTH];
  logic [SAMPLE_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [LVL_W-1:0]    level;
  logic                ready_en;
  logic                fifo_empty;
  logic                fifo_full;
  logic                push;
  logic                pop;

  // Pair loaded into the shift registers at the frame boundary
  logic [SAMPLE_W-1:0] load_l;
  logic [SAMPLE_W-1:0] load_r;

  // MCLK divider: free-running counter, output toggles every MCLK_DIV/2 cycles
  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      mclk_cnt <= '0;
      mclk_q   <= 1'b0;
    end else if (mclk_cnt == MCW'(MHALF - 1)) begin
      mclk_cnt <= '0;
      mclk_q   <= ~mclk_q;
    end else begin
      mclk_cnt <= mclk_cnt + MCW'(1);
    end
  end

  // SCLK divider: same scheme, SCLK_DIV/2 cycles per half period
  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      sclk_cnt <= '0;
      sclk_q   <= 1'b0;
    end else if (sclk_cnt == SCW'(SHALF - 1)) begin
      sclk_cnt <= '0;
      sclk_q   <= ~sclk_q;
    end else begin
      sclk_cnt <= sclk_cnt + SCW'(1);
    end
  end

  // fall_tick marks the cycle in which SCLK is about to be driven 1->0.
  // Every framing register moves on this strobe, so DAC and LRCK change
  // together with the SCLK falling edge.
  assign fall_tick  = sclk_q && (sclk_cnt == SCW'(SHALF - 1));
  assign frame_wrap = fall_tick && (bit_cnt == 6'd63);

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
  assign pop        = frame_wrap && !fifo_empty;

  // A full FIFO still accepts a pair in the load cycle. The pop frees the
  // slot in that same cycle. ready depends only on registered state, so
  // there is no path from sample_valid. ready_en keeps ready low while
  // reset is held.
  assign sample_ready = ready_en && (!fifo_full || pop);
  assign push         = sample_valid && sample_ready;

  // Frame load source. The FIFO head is used when data is present;
  // otherwise the underrun value is used.
  always_comb begin
    load_l = '0;
    load_r = '0;
    if (!fifo_empty) begin
      load_l = mem_l[rd_ptr];
      load_r = mem_r[rd_ptr];
    end else begin
`ifdef I2S_UNDERRUN_HOLD_EN
      load_l = held_l;
      load_r = held_r;
`else
      load_l = '0;
      load_r = '0;
`endif
    end
  end

  // FIFO storage. The contents need no reset, because level and pointers
  // decide what is valid. When the FIFO is full, a push writes the slot
  // that the concurrent pop is reading. The read sees the old value, so
  // the order is preserved.
  always_ff @(posedge clk_audio) begin
    if (push) begin
      mem_l[wr_ptr] <= sample_l;
      mem_r[wr_ptr] <= sample_r;
    end
  end

  // FIFO pointers and occupancy. Pointers wrap naturally at the
  // power-of-two depth.
  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Bit counter and serialiser. The DAC register receives the bit that
  // belongs to the new bit_cnt value, which gives the one-bit I2S delay.
  // Bit_cnt values 0..31 advance the left slot and 32..62 advance the
  // right slot. Each slot is left-aligned, so the padding bits come out
  // as zeros.
  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt    <= '0;
      shift_l    <= '0;
      shift_r    <= '0;
      dac_q      <= 1'b0;
      underrun_q <= 1'b0;
      held_l     <= '0;
      held_r     <= '0;
    end else begin
      underrun_q <= frame_wrap && fifo_empty;
      if (fall_tick) begin
        bit_cnt <= bit_cnt + 6'd1;
        if (frame_wrap) begin
          shift_l <= {load_l, {PAD_W{1'b0}}};
          shift_r <= {load_r, {PAD_W{1'b0}}};
          dac_q   <= 1'b0;
          if (!fifo_empty) begin
            held_l <= load_l;
            held_r <= load_r;
          end
        end else if (!bit_cnt[5]) begin
          dac_q   <= shift_l[31];
          shift_l <= {shift_l[30:0], 1'b0};
        end else begin
          dac_q   <= shift_r[31];
          shift_r <= {shift_r[30:0], 1'b0};
        end
      end
    end
  end

  assign audio_mclk = mclk_q;
  assign audio_sclk = sclk_q;
  assign audio_lrck = bit_cnt[5];
  assign audio_dac  = dac_q;
  assign underrun   = underrun_q;
  assign fifo_level = level;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// -----------------------------------------------------------------------------
// tb_i2s_audio_tx
//
// Self-checking bench for i2s_audio_tx with default parameters.
// A table of per-frame records pushes sample pairs and holds the expected
// serial contents of each frame. Hand-written sequences cover reset, clock
// ratios, FIFO full/stall and simultaneous push/pop at full.
// -----------------------------------------------------------------------------
module tb_i2s_audio_tx;

`ifdef I2S_UNDERRUN_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  localparam logic [63:0] DATA_MASK = 64'h0001_FFFE_0001_FFFE;
  localparam logic [63:0] LRCK_EXP  = 64'hFFFF_FFFF_0000_0000;

  logic        clk_audio;
  logic        reset_n;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic        sample_valid;
  logic        sample_ready;
  logic        audio_mclk;
  logic        audio_lrck;
  logic        audio_dac;
  logic        audio_sclk;
  logic        underrun;
  logic [2:0]  fifo_level;

  int errors = 0;
  int checks = 0;

  logic [63:0] frame_bits;
  logic [63:0] frame_lrck;
  int          unr_extra;

  typedef struct {
    bit          push;
    logic [15:0] l;
    logic [15:0] r;
    bit          exp_unr;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
  } vec_t;

  vec_t vecs[7];
  logic [15:0] pl[6];
  logic [15:0] pr[6];

  i2s_audio_tx dut (
    .clk_audio    (clk_audio),
    .reset_n      (reset_n),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .audio_mclk   (audio_mclk),
    .audio_lrck   (audio_lrck),
    .audio_dac    (audio_dac),
    .audio_sclk   (audio_sclk),
    .underrun     (underrun),
    .fifo_level   (fifo_level)
  );

  initial clk_audio = 1'b0;
  always #5 clk_audio = ~clk_audio;

  // One comparison: counts it and reports a failure line on mismatch
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Present one pair for a single cycle starting at a negedge
  task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r);
    sample_l     = l;
    sample_r     = r;
    sample_valid = 1'b1;
    @(negedge clk_audio);
    sample_valid = 1'b0;
  endtask

  // Waits until the negedge right after an LRCK 1->0 edge (frame wrap)
  task automatic waitFrameStart();
    logic prev;
    int   n;
    bit   found;
    prev  = audio_lrck;
    found = 1'b0;
    n     = 0;
    while (!found && n < 2200) begin
      @(negedge clk_audio);
      n++;
      if (prev && !audio_lrck) found = 1'b1;
      prev = audio_lrck;
    end
    if (!found) checkOutput("frame_start_timeout", 64'd0, 64'd1);
  endtask

  // Records DAC and LRCK on 64 consecutive SCLK rising edges
  task automatic captureFrame();
    logic prev;
    int   k;
    int   n;
    k          = 0;
    n          = 0;
    unr_extra  = 0;
    frame_bits = '0;
    frame_lrck = '0;
    prev       = audio_sclk;
    while (k < 64 && n < 1200) begin
      @(negedge clk_audio);
      n++;
      if (underrun) unr_extra++;
      if (!prev && audio_sclk) begin
        frame_bits[k[5:0]] = audio_dac;
        frame_lrck[k[5:0]] = audio_lrck;
        k++;
      end
      prev = audio_sclk;
    end
    if (k != 64) checkOutput("capture_timeout", 64'(k), 64'd64);
  endtask

  task automatic checkFrame(input string tag, input logic [15:0] el,
                            input logic [15:0] er);
    logic [15:0] l;
    logic [15:0] r;
    for (int j = 0; j < 16; j++) begin
      l[15-j] = frame_bits[1+j];
      r[15-j] = frame_bits[33+j];
    end
    checkOutput({tag, "_left"},  64'(l), 64'(el));
    checkOutput({tag, "_right"}, 64'(r), 64'(er));
    checkOutput({tag, "_pad"},   frame_bits & ~DATA_MASK, 64'd0);
    checkOutput({tag, "_lrck"},  frame_lrck, LRCK_EXP);
    checkOutput({tag, "_unr_width"}, 64'(unr_extra), 64'd0);
  endtask

  initial begin
    int mclk_hi, sclk_hi, lrck_hi, mclk_re, sclk_re, lrck_re;
    logic pm, ps, plr;

    // Per-frame table: the push feeds the next frame; the exp_* fields
    // describe the frame captured in the same iteration
    vecs[0] = '{1'b1, 16'hA5F0, 16'h0F5A, 1'b1, 16'h0000, 16'h0000};
    vecs[1] = '{1'b1, 16'h1234, 16'h8001, 1'b0, 16'hA5F0, 16'h0F5A};
    vecs[2] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h1234, 16'h8001};
    vecs[3] = '{1'b0, 16'h0000, 16'h0000, 1'b1,
                HOLD ? 16'h1234 : 16'h0000, HOLD ? 16'h8001 : 16'h0000};
    vecs[4] = '{1'b1, 16'h7FFF, 16'hFFFF, 1'b1,
                HOLD ? 16'h1234 : 16'h0000, HOLD ? 16'h8001 : 16'h0000};
    vecs[5] = '{1'b1, 16'h0001, 16'h8000, 1'b0, 16'h7FFF, 16'hFFFF};
    vecs[6] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0001, 16'h8000};

    pl = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
    pr = '{16'hEEEE, 16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA, 16'h9999};

    reset_n      = 1'b0;
    sample_l     = '0;
    sample_r     = '0;
    sample_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk_audio);
    checkOutput("reset_outputs",
                64'({audio_mclk, audio_sclk, audio_lrck, audio_dac, underrun,
                     sample_ready, fifo_level}), 64'd0);
    reset_n = 1'b1;
    @(negedge clk_audio);
    checkOutput("release_ready", 64'(sample_ready), 64'd1);
    checkOutput("release_level", 64'(fifo_level), 64'd0);

    // Free-run clock ratios and duty over 2048 cycles
    mclk_hi = 0; sclk_hi = 0; lrck_hi = 0;
    mclk_re = 0; sclk_re = 0; lrck_re = 0;
    pm = audio_mclk; ps = audio_sclk; plr = audio_lrck;
    for (int c = 0; c < 2048; c++) begin
      @(negedge clk_audio);
      if (audio_mclk) mclk_hi++;
      if (audio_sclk) sclk_hi++;
      if (audio_lrck) lrck_hi++;
      if (!pm && audio_mclk) mclk_re++;
      if (!ps && audio_sclk) sclk_re++;
      if (!plr && audio_lrck) lrck_re++;
      pm = audio_mclk; ps = audio_sclk; plr = audio_lrck;
    end
    checkOutput("mclk_periods", 64'(mclk_re), 64'd512);
    checkOutput("mclk_high",    64'(mclk_hi), 64'd1024);
    checkOutput("sclk_periods", 64'(sclk_re), 64'd128);
    checkOutput("sclk_high",    64'(sclk_hi), 64'd1024);
    checkOutput("lrck_periods", 64'(lrck_re), 64'd2);
    checkOutput("lrck_high",    64'(lrck_hi), 64'd1024);

    // Table-driven frames
    for (int i = 0; i < 7; i++) begin
      waitFrameStart();
      checkOutput($sformatf("vec%0d_underrun", i), 64'(underrun), 64'(vecs[i].exp_unr));
      if (vecs[i].push) applyStimulus(vecs[i].l, vecs[i].r);
      captureFrame();
      checkFrame($sformatf("vec%0d", i), vecs[i].exp_l, vecs[i].exp_r);
    end

    // FIFO fill: five back-to-back offers, the fifth stalls
    waitFrameStart();
    checkOutput("fill_start_underrun", 64'(underrun), 64'd1);
    for (int i = 0; i < 5; i++) begin
      sample_l     = pl[i];
      sample_r     = pr[i];
      sample_valid = 1'b1;
      checkOutput($sformatf("fill_ready%0d", i), 64'(sample_ready), (i < 4) ? 64'd1 : 64'd0);
      @(negedge clk_audio);
    end
    sample_valid = 1'b0;
    checkOutput("full_level", 64'(fifo_level), 64'd4);
    checkOutput("full_ready", 64'(sample_ready), 64'd0);

    // At the wrap one entry leaves and ready returns
    waitFrameStart();
    checkOutput("wrap_level", 64'(fifo_level), 64'd3);
    checkOutput("wrap_ready", 64'(sample_ready), 64'd1);
    applyStimulus(pl[4], pr[4]);
    checkOutput("refill_level", 64'(fifo_level), 64'd4);
    captureFrame();
    checkFrame("order_p0", pl[0], pr[0]);

    // Hold valid while full: the push lands in the load cycle
    sample_l     = pl[5];
    sample_r     = pr[5];
    sample_valid = 1'b1;
    waitFrameStart();
    sample_valid = 1'b0;
    checkOutput("pushpop_level", 64'(fifo_level), 64'd4);
    checkOutput("pushpop_ready", 64'(sample_ready), 64'd0);
    checkOutput("pushpop_underrun", 64'(underrun), 64'd0);
    captureFrame();
    checkFrame("order_p1", pl[1], pr[1]);
    for (int i = 2; i < 6; i++) begin
      waitFrameStart();
      captureFrame();
      checkFrame($sformatf("order_p%0d", i), pl[i], pr[i]);
    end
    waitFrameStart();
    checkOutput("drain_underrun", 64'(underrun), 64'd1);

    // Reset asserted mid-frame with data buffered
    applyStimulus(16'h7777, 16'h1357);
    repeat (600) @(negedge clk_audio);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midframe_reset_outputs",
                64'({audio_mclk, audio_sclk, audio_lrck, audio_dac, underrun,
                     sample_ready, fifo_level}), 64'd0);
    repeat (2) @(negedge clk_audio);
    reset_n = 1'b1;
    @(negedge clk_audio);
    checkOutput("rerelease_ready", 64'(sample_ready), 64'd1);
    checkOutput("rerelease_level", 64'(fifo_level), 64'd0);
    waitFrameStart();
    checkOutput("post_reset_underrun", 64'(underrun), 64'd1);
    captureFrame();
    checkFrame("post_reset", 16'h0000, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
